aes_add_round_key_stage: RTL and testbench
==========================================

// Module: aes_add_round_key_stage
// PURPOSE
// - Registered AddRoundKey pipeline stage of the aes128 datapath: out = state ^ round_key.
// - The XOR itself maps onto the XOR2X1 cell array. This block adds the registered
//   valid/ready handshake, a 2-entry skid buffer, round tagging and round-range checking.
// - Sits between the key-schedule/MixColumns outputs upstream and the next SubBytes stage.
// PARAMETERS
// - DATA_W      128  state/key width in bits; must be a multiple of 8
// - ROUND_W     4    width of the round tag
// - LAST_ROUND  10   round index that marks the final AddRoundKey
// PORTS
// - CLK        in   1        clock, rising edge
// - RSTB       in   1        asynchronous active-low reset
// - IN_STATE   in   DATA_W   input state
// - IN_KEY     in   DATA_W   round key, aligned with IN_STATE
// - IN_ROUND   in   ROUND_W  round tag of the input beat
// - IN_VALID   in   1        input beat valid
// - IN_READY   out  1        stage can accept a beat
// - OUT_DATA   out  DATA_W   IN_STATE ^ IN_KEY of the head beat
// - OUT_ROUND  out  ROUND_W  round tag of the head beat
// - OUT_LAST   out  1        head beat has round == LAST_ROUND
// - OUT_VALID  out  1        head beat valid
// - OUT_READY  in   1        downstream accepts the head beat
// - ERR_ROUND  out  1        sticky: a beat with round > LAST_ROUND was accepted
// BEHAVIOUR
// - Reset (RSTB=0, asynchronous): main and skid entries empty.
//   - OUT_VALID=0, OUT_DATA=0, OUT_ROUND=0, OUT_LAST=0, ERR_ROUND=0, IN_READY=1.
//   - Reset mid-transfer drops both entries. No partial beat is emitted after release.
// - Accept: IN_VALID & IN_READY at the CLK edge. XOR, tag and LAST are computed and
//   stored at accept.
// - Emit: OUT_VALID & OUT_READY at the CLK edge.
// - Latency: 1 cycle. A beat accepted at edge N is on OUT_* after edge N; no combinational in->out path.
// - IN_READY = !skid_valid. It is a pure register output: no combinational path from OUT_READY.
// - Entry update per edge (main = output register, skid = overflow):
//   - main empty, accept -> load main.
//   - main full, emit, skid full -> main<=skid, skid empties; the input is not ready in this case.
//   - main full, emit, skid empty, accept -> main<=new.
//   - main full, emit, no accept -> main empties.
//   - main full, no emit, accept -> load skid; IN_READY drops next cycle.
//   - main full, no emit, no accept -> hold.
// - Ordering: beats leave strictly in acceptance order. Throughput is 1 beat/cycle sustained.
// - Capacity: 2 beats. With the skid full and OUT_READY=0, IN_READY=0 and all state holds.
// - OUT_* stay stable while OUT_VALID & !OUT_READY.
// - Round check: round > LAST_ROUND still passes data unchanged, and sets ERR_ROUND
//   at accept. ERR_ROUND clears only on reset.
// - OUT_LAST uses an exact equality compare on ROUND_W bits; there is no wrap handling.
// - Simultaneous emit and accept with the skid empty: no bubble, and the skid stays empty.
// CONFIGURATION
// - Macro ARK_PARITY_EN.
// - Defined:
//   - Adds output OUT_PARITY [DATA_W/8] = even parity per byte of OUT_DATA
//     (bit i = ^OUT_DATA[8i+7:8i]).
//   - Parity is computed at accept and stored alongside the data, so it carries the same
//     1-cycle latency, stalls with the data and resets to 0.
// - Undefined: the port and its registers are absent; all other behaviour is identical.
// TESTING
// - FIPS-197 vector: IN_STATE=3243f6a8885a308d313198a2e0370734,
//   IN_KEY=2b7e151628aed2a6abf7158809cf4f3c, IN_ROUND=0
//   -> next cycle OUT_DATA=193de3bea0f4e22b9ac68d2ae9f84808, OUT_ROUND=0, OUT_LAST=0.
// - Back-pressure: OUT_READY=0, three beats offered (tags 1,2,3)
//   -> tags 1,2 accepted, IN_READY=0 from the cycle after the 2nd accept.
//   - Release OUT_READY -> outputs 1,2,3 in order, with no loss or duplication.
// - Streaming: IN_VALID=OUT_READY=1 for 20 cycles, random data
//   -> 20 outputs, one per cycle, each equal to state^key; IN_READY stays 1.
// - Round bounds: IN_ROUND=10 -> OUT_LAST=1, ERR_ROUND=0.
//   - Then IN_ROUND=12 -> beat passes, ERR_ROUND=1 and stays 1 until RSTB.
// - Reset mid-operation: skid full, assert RSTB=0 asynchronously
//   -> OUT_VALID=0 and IN_READY=1 immediately.
//   - After release, the first output is the first new beat.
// - With ARK_PARITY_EN: OUT_DATA byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0;
//   stalled beats keep their parity.

Source files
------------

// File: rtl/aes_add_round_key_stage_if.sv
// ---------------------------------------------------------------------------
// aes_add_round_key_stage_if
// Stream bundle around the AddRoundKey stage: the upstream beat (state, key,
// round tag) with its valid/ready pair, and the downstream result beat with
// its valid/ready pair plus the sticky round-range error flag.
//
// Signals
//   in_state / in_key  [DATA_W]   input state and aligned round key
//   in_round           [ROUND_W]  round tag of the input beat
//   in_valid / in_ready           upstream handshake
//   out_data           [DATA_W]   state ^ key of the head beat
//   out_round          [ROUND_W]  round tag of the head beat
//   out_last                      head beat is the final round
//   out_valid / out_ready         downstream handshake
//   err_round                     sticky out-of-range round flag
//   out_parity         [DATA_W/8] per-byte even parity (only with ARK_PARITY_EN)
//
// Modports
//   slave  : the stage itself (consumes in_*, produces out_*)
//   master : the environment around the stage
//
// Optional feature macro: ARK_PARITY_EN
// ---------------------------------------------------------------------------
interface aes_add_round_key_stage_if #(
  parameter int DATA_W  = 128,
  parameter int ROUND_W = 4
);
  logic [DATA_W-1:0]   in_state;
  logic [DATA_W-1:0]   in_key;
  logic [ROUND_W-1:0]  in_round;
  logic                in_valid;
  logic                in_ready;

  logic [DATA_W-1:0]   out_data;
  logic [ROUND_W-1:0]  out_round;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;
  logic                err_round;
`ifdef ARK_PARITY_EN
  logic [DATA_W/8-1:0] out_parity;
`endif

  modport slave (
    input  in_state, in_key, in_round, in_valid, out_ready,
`ifdef ARK_PARITY_EN
    output out_parity,
`endif
    output in_ready, out_data, out_round, out_last, out_valid, err_round
  );

  modport master (
    output in_state, in_key, in_round, in_valid, out_ready,
`ifdef ARK_PARITY_EN
    input  out_parity,
`endif
    input  in_ready, out_data, out_round, out_last, out_valid, err_round
  );
endinterface

// File: rtl/aes_add_round_key_stage.sv
// ---------------------------------------------------------------------------
// aes_add_round_key_stage
// Registered AddRoundKey stage of the aes128 datapath: out = state ^ key.
// A main output register plus one skid entry give a two-beat buffer so that
// in_ready is a pure register output (no combinational path from out_ready)
// while still sustaining one beat per cycle. The XOR, round tag, last flag
// and (optionally) byte parity are all computed at accept time and stored.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset; empties both entries
//   bus    : aes_add_round_key_stage_if.slave (see interface header)
//
// Parameters
//   DATA_W     : state/key width, multiple of 8
//   ROUND_W    : round tag width
//   LAST_ROUND : round index of the final AddRoundKey
//
// Optional feature macro: ARK_PARITY_EN adds bus.out_parity, per-byte even
// parity of out_data, carried alongside the data.
// ---------------------------------------------------------------------------
module aes_add_round_key_stage #(
  parameter int DATA_W     = 128,
  parameter int ROUND_W    = 4,
  parameter int LAST_ROUND = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  aes_add_round_key_stage_if.slave   bus
);

  localparam logic [ROUND_W-1:0] LAST_TAG = ROUND_W'(LAST_ROUND);

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [ROUND_W-1:0]  round;
    logic                last;
`ifdef ARK_PARITY_EN
    logic [DATA_W/8-1:0] parity;
`endif
  } beat_t;

  beat_t main_q;
  beat_t skid_q;
  beat_t new_beat;
  logic  main_valid;
  logic  skid_valid;
  logic  err_q;
  logic  accept;
  logic  emit;
  logic  new_err;

  // The skid entry only fills while main is stalled, so readiness is simply
  // "skid has room" and never looks at out_ready.
  assign accept = bus.in_valid & ~skid_valid;
  assign emit   = main_valid & bus.out_ready;

  // Everything the downstream needs is derived here, once, at accept time.
  always_comb begin
    new_beat       = '0;
    new_beat.data  = bus.in_state ^ bus.in_key;
    new_beat.round = bus.in_round;
    new_beat.last  = (bus.in_round == LAST_TAG);
`ifdef ARK_PARITY_EN
    for (int i = 0; i < DATA_W/8; i++) begin
      new_beat.parity[i] = ^new_beat.data[8*i +: 8];
    end
`endif
    new_err = (bus.in_round > LAST_TAG);
  end

  // Entry management. When main is empty the skid is always empty too, so a
  // new beat can go straight to main. When main drains while the skid holds a
  // beat, the skid moves up; in_ready is low then, so no accept competes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (!main_valid) begin
        if (accept) begin
          main_q     <= new_beat;
          main_valid <= 1'b1;
        end
      end else if (emit) begin
        if (skid_valid) begin
          main_q     <= skid_q;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_q <= new_beat;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_q     <= new_beat;
        skid_valid <= 1'b1;
      end

      if (accept && new_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = ~skid_valid;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_q.data;
  assign bus.out_round = main_q.round;
  assign bus.out_last  = main_q.last;
  assign bus.err_round = err_q;
`ifdef ARK_PARITY_EN
  assign bus.out_parity = main_q.parity;
`endif

endmodule

// File: tb/tb_aes_add_round_key_stage.sv
// ---------------------------------------------------------------------------
// tb_aes_add_round_key_stage
// Directed bench for the AddRoundKey stage: reset values, the FIPS-197 first
// AddRoundKey, back-pressure through the skid entry, a 20-beat stream,
// round-range flags, asynchronous reset with the skid full, and (with
// ARK_PARITY_EN) per-byte parity.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_aes_add_round_key_stage;

  localparam int DATA_W  = 128;
  localparam int ROUND_W = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  aes_add_round_key_stage_if #(.DATA_W(DATA_W), .ROUND_W(ROUND_W)) bus ();

  aes_add_round_key_stage #(
    .DATA_W(DATA_W),
    .ROUND_W(ROUND_W),
    .LAST_ROUND(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts a failure and reports.
  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one input beat (valid held until changed).
  task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] state,
                               input logic [DATA_W-1:0] key,
                               input logic [ROUND_W-1:0] round);
    bus.in_valid = valid;
    bus.in_state = state;
    bus.in_key   = key;
    bus.in_round = round;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] s;
  logic [DATA_W-1:0] k;
  logic [DATA_W-1:0] exp_data;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, '0, '0, '0);
    #1;

    // Reset values
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_out_round", bus.out_round, 0);
    checkOutput("rst_out_last", bus.out_last, 0);
    checkOutput("rst_err_round", bus.err_round, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    #10;
    rst_n = 1'b1;
    step();

    // FIPS-197 initial AddRoundKey
    applyStimulus(1'b1, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("fips_valid", bus.out_valid, 1);
    checkOutput("fips_data", bus.out_data, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    checkOutput("fips_round", bus.out_round, 0);
    checkOutput("fips_last", bus.out_last, 0);
    step();
    checkOutput("fips_drained", bus.out_valid, 0);

    // Back-pressure: tags 1,2 accepted, tag 3 held off
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, {4{32'hAAAAAAAA}}, {4{32'h55555555}}, 4'd1);
    step();
    checkOutput("bp_t1_valid", bus.out_valid, 1);
    checkOutput("bp_t1_round", bus.out_round, 1);
    checkOutput("bp_ready_after_1", bus.in_ready, 1);
    applyStimulus(1'b1, 128'h123456789abcdef00fedcba987654321,
                  128'h123456789abcdef00fedcba987654321, 4'd2);
    step();
    checkOutput("bp_ready_after_2", bus.in_ready, 0);
    checkOutput("bp_head_still_1", bus.out_round, 1);
    applyStimulus(1'b1, 128'h0123456789abcdef0123456789abcdef,
                  128'hffffffffffffffff0000000000000000, 4'd3);
    step();
    checkOutput("bp_full_ready", bus.in_ready, 0);
    checkOutput("bp_full_round", bus.out_round, 1);
    checkOutput("bp_full_data", bus.out_data, {4{32'hFFFFFFFF}});
    bus.out_ready = 1'b1;
    step();
    checkOutput("bp_out2_round", bus.out_round, 2);
    checkOutput("bp_out2_data", bus.out_data, 0);
    checkOutput("bp_out2_ready", bus.in_ready, 1);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("bp_out3_valid", bus.out_valid, 1);
    checkOutput("bp_out3_round", bus.out_round, 3);
    checkOutput("bp_out3_data", bus.out_data, 128'hfedcba98765432100123456789abcdef);
    step();
    checkOutput("bp_drained", bus.out_valid, 0);

    // Streaming: one beat per cycle, 1-cycle latency
    for (int i = 0; i < 20; i++) begin
      s = {$urandom(), $urandom(), $urandom(), $urandom()};
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp_data = s ^ k;
      applyStimulus(1'b1, s, k, 4'(i % 10));
      step();
      checkOutput($sformatf("stream_data_%0d", i), bus.out_data, exp_data);
      checkOutput($sformatf("stream_round_%0d", i), bus.out_round, DATA_W'(i % 10));
      checkOutput($sformatf("stream_ready_%0d", i), bus.in_ready, 1);
    end
    applyStimulus(1'b0, '0, '0, '0);
    step();
    checkOutput("stream_drained", bus.out_valid, 0);

    // Round bounds
    applyStimulus(1'b1, 128'h1, 128'h3, 4'd10);
    step();
    checkOutput("r10_last", bus.out_last, 1);
    checkOutput("r10_data", bus.out_data, 128'h2);
    checkOutput("r10_err", bus.err_round, 0);
    applyStimulus(1'b1, 128'hff, 128'h0f, 4'd12);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("r12_round", bus.out_round, 12);
    checkOutput("r12_last", bus.out_last, 0);
    checkOutput("r12_data", bus.out_data, 128'hf0);
    checkOutput("r12_err", bus.err_round, 1);
    step();
    step();
    checkOutput("r12_err_sticky", bus.err_round, 1);

    // Asynchronous reset with the skid full
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 128'hA, 128'h0, 4'd1);
    step();
    applyStimulus(1'b1, 128'hB, 128'h0, 4'd2);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("mid_skid_full", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", bus.out_valid, 0);
    checkOutput("mid_rst_ready", bus.in_ready, 1);
    checkOutput("mid_rst_err", bus.err_round, 0);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    checkOutput("mid_no_partial", bus.out_valid, 0);
    applyStimulus(1'b1, 128'h5, 128'h0, 4'd5);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("mid_first_round", bus.out_round, 5);
    checkOutput("mid_first_data", bus.out_data, 128'h5);
    step();
    checkOutput("mid_drained", bus.out_valid, 0);

`ifdef ARK_PARITY_EN
    // Parity: byte0 = 0x03 -> 0, byte1 = 0x07 -> 1, held while stalled
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 128'h0703, 128'h0, 4'd1);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("par_value", DATA_W'(bus.out_parity), 128'h2);
    step();
    checkOutput("par_stalled", DATA_W'(bus.out_parity), 128'h2);
    bus.out_ready = 1'b1;
    step();
    checkOutput("par_drained", bus.out_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
